// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel button debouncer.
// Latency: none (types and constant functions only).
// Backpressure: none.
package debounce_pkg;

   // Per-channel lock-out FSM; the 2-bit encoding is relied on by nothing
   // outside the channel, but is kept fixed so state dumps read the same.
   typedef enum logic [1:0] {
      S_WAIT_LOW  = 2'd0,
      S_CNT_HIGH  = 2'd1,
      S_WAIT_HIGH = 2'd2,
      S_CNT_LOW   = 2'd3
   } state_t;

   // Number of tp_i ticks in one lock-out window.
   function automatic int max_count(input int deb_ns, input int pulse_ns);
      return deb_ns / pulse_ns;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced button: synchroniser, lock-out FSM, tick counter, edge pulses.
// Latency: raw edge -> btn_o is SYNC_STAGES+1 clk_i cycles; pulses coincide with the btn_o change.
// Backpressure: none; free-running, every input sample is consumed.
//
// Ports: clk_i, rstn_i (async active-low), tp_i (timebase tick), btn_i (raw level),
//        btn_o (debounced level), rise_o/fall_o (one-cycle edge pulses), long_o (long-press pulse).
// Optional feature: DEBOUNCE_LONGPRESS_EN adds the hold counter behind long_o.
module debounce_chan
   import debounce_pkg::*;
#(
   parameter int MAX_COUNT   = 4,
   parameter int SYNC_STAGES = 2
`ifdef DEBOUNCE_LONGPRESS_EN
   ,
   parameter int LONG_COUNT  = 244_140
`endif
)
(
   input  logic clk_i,
   input  logic rstn_i,
   input  logic tp_i,
   input  logic btn_i,
   output logic btn_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);

   localparam int          CW       = $clog2(MAX_COUNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(MAX_COUNT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   btn_q;

   // Input synchroniser for the asynchronous pin.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_WAIT_LOW;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_o;
      end
   end

   // In the CNT states the synchronised input is deliberately not looked at:
   // that is the lock-out that swallows contact bounce. The counter is held
   // at zero outside CNT states, so the first tick of a window may be partial.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         S_WAIT_LOW: begin
            if (s) state_d = S_CNT_HIGH;
         end
         S_CNT_HIGH, S_CNT_LOW: begin
            cnt_d = cnt_q;
            if (tp_i) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = (state_q == S_CNT_HIGH) ? S_WAIT_HIGH : S_WAIT_LOW;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WAIT_HIGH: begin
            if (!s) state_d = S_CNT_LOW;
         end
         default: state_d = S_WAIT_LOW;
      endcase
   end

   // Level decodes straight from the state register; the pulses compare it
   // with its own one-cycle-old copy, which resets to 0 so reset release is silent.
   assign btn_o  = (state_q == S_CNT_HIGH) || (state_q == S_WAIT_HIGH);
   assign rise_o = btn_o & ~btn_q;
   assign fall_o = ~btn_o & btn_q;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int            HW        = $clog2(LONG_COUNT) + 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);
   localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_COUNT);

   logic [HW-1:0] hold_q;
   logic          long_q;

   // Saturating at the threshold makes the pulse fire at most once per press.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (!btn_o) begin
            hold_q <= '0;
         end else if (tp_i && (hold_q != HOLD_SAT)) begin
            hold_q <= hold_q + 1'b1;
            long_q <= (hold_q == HOLD_LAST);
         end
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel button debouncer: N_CH independent channels sharing clock, reset and tick.
// Latency: raw edge -> btn_o is SYNC_STAGES+1 clk_i cycles per channel.
// Backpressure: none; outputs are levels and one-cycle pulses with no handshake.
//
// Ports: clk_i, rstn_i (async active-low), tp_i (tick every PULSE_PER_NS),
//        btn_i[N_CH] raw pins, btn_o/rise_o/fall_o/long_o[N_CH] per-channel results.
// Optional feature: DEBOUNCE_LONGPRESS_EN enables long_o and the LONG_PER_NS parameter;
// without it long_o is constant 0.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH            = 4,
   parameter int PULSE_PER_NS    = 4096,
   parameter int DEBOUNCE_PER_NS = 16_777_216,
   parameter int SYNC_STAGES     = 2
`ifdef DEBOUNCE_LONGPRESS_EN
   ,
   parameter int LONG_PER_NS     = 1_000_000_000
`endif
)
(
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            tp_i,
   input  logic [N_CH-1:0] btn_i,
   output logic [N_CH-1:0] btn_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic [N_CH-1:0] long_o
);

   localparam int MAX_COUNT = max_count(DEBOUNCE_PER_NS, PULSE_PER_NS);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      debounce_chan #(
         .MAX_COUNT   (MAX_COUNT),
         .SYNC_STAGES (SYNC_STAGES)
`ifdef DEBOUNCE_LONGPRESS_EN
         ,
         .LONG_COUNT  (LONG_PER_NS / PULSE_PER_NS)
`endif
      ) u_chan (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .tp_i   (tp_i),
         .btn_i  (btn_i[k]),
         .btn_o  (btn_o[k]),
         .rise_o (rise_o[k]),
         .fall_o (fall_o[k]),
         .long_o (long_o[k])
      );
   end

endmodule
